// File: rtl/winograd_pkg.sv
// Shared definitions for the Winograd F(2x2,3x3) pre/post transform blocks.
package winograd_pkg;

  typedef enum logic [2:0] {
    ROW0  = 3'd0,
    ROW1  = 3'd1,
    ROW2  = 3'd2,
    ROW3  = 3'd3,
    EMIT0 = 3'd4,
    EMIT1 = 3'd5
  } post_state_t;

  localparam int TILE_IN  = 4;
  localparam int TILE_OUT = 2;

  localparam logic MODE_RFCONV   = 1'b1;
  localparam logic MODE_RFDECONV = 1'b0;

endpackage

// File: rtl/post_tu_1d.sv
// 1-D A^T kernel of the F(2,3) output transform: (a+b+c, b-c-d).
// Output is two bits wider than the input, so no sum can overflow.
module post_tu_1d #(
  parameter int W = 16
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  input  logic signed [W-1:0] c,
  input  logic signed [W-1:0] d,
  output logic signed [W+1:0] s0,
  output logic signed [W+1:0] s1
);

  logic signed [W+1:0] ax, bx, cx, dx;

  assign ax = a;
  assign bx = b;
  assign cx = c;
  assign dx = d;

  assign s0 = ax + bx + cx;
  assign s1 = bx - cx - dx;

endmodule

// File: rtl/post_tu_2d.sv
// Streaming 2-D Winograd F(2x2,3x3) output transform Y = A^T * M * A.
// Four M rows are row-transformed into the T buffer, then two Y rows are
// column-transformed, rounded, shifted and saturated on the way out.
//
// state | meaning
// ROW0  | waiting for M row 0 (latches tile mode)
// ROW1  | waiting for M row 1
// ROW2  | waiting for M row 2
// ROW3  | waiting for M row 3
// EMIT0 | presenting Y row 0
// EMIT1 | presenting Y row 1
module post_tu_2d
  import winograd_pkg::*;
#(
  parameter int DW    = 16,
  parameter int OW    = 16,
  parameter int SHIFT = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mode,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_m0,
  input  logic signed [DW-1:0] in_m1,
  input  logic signed [DW-1:0] in_m2,
  input  logic signed [DW-1:0] in_m3,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [OW-1:0] out_y0,
  output logic signed [OW-1:0] out_y1,
  output logic                 out_row,
  output logic                 out_sat
);

  localparam logic [2:0] S_ROW0  = ROW0;
  localparam logic [2:0] S_ROW1  = ROW1;
  localparam logic [2:0] S_ROW2  = ROW2;
  localparam logic [2:0] S_ROW3  = ROW3;
  localparam logic [2:0] S_EMIT0 = EMIT0;
  localparam logic [2:0] S_EMIT1 = EMIT1;

  localparam int TW = DW + 2;
  localparam int YW = DW + 4;
  // One extra bit so the rounding add cannot wrap.
  localparam int XW = DW + 5;

  localparam logic signed [XW-1:0] SAT_HI = XW'((64'sd1 <<< (OW - 1)) - 64'sd1);
  localparam logic signed [XW-1:0] SAT_LO = XW'(-(64'sd1 <<< (OW - 1)));
  localparam logic signed [XW-1:0] RND    =
    (SHIFT > 0) ? XW'(64'sd1 <<< ((SHIFT > 0) ? (SHIFT - 1) : 0)) : '0;

  logic [2:0]           state, state_nxt;
  logic                 tile_mode;
  logic                 emit, accept;
  logic signed [TW-1:0] t_c0 [TILE_IN];
  logic signed [TW-1:0] t_c1 [TILE_IN];
  logic signed [TW-1:0] row_s0, row_s1;
  logic signed [YW-1:0] y_c0 [TILE_OUT];
  logic signed [YW-1:0] y_c1 [TILE_OUT];
  logic signed [YW-1:0] sel  [TILE_OUT];
  logic signed [XW-1:0] ext  [TILE_OUT];
  logic signed [XW-1:0] shf  [TILE_OUT];
  logic signed [OW-1:0] clip [TILE_OUT];
  logic [TILE_OUT-1:0]  hit;

  assign emit     = (state == S_EMIT0) || (state == S_EMIT1);
  assign in_ready = !emit;
  assign accept   = in_valid && in_ready;

  post_tu_1d #(.W(DW)) u_row (
    .a(in_m0), .b(in_m1), .c(in_m2), .d(in_m3), .s0(row_s0), .s1(row_s1)
  );

  post_tu_1d #(.W(TW)) u_col0 (
    .a(t_c0[0]), .b(t_c0[1]), .c(t_c0[2]), .d(t_c0[3]), .s0(y_c0[0]), .s1(y_c0[1])
  );

  post_tu_1d #(.W(TW)) u_col1 (
    .a(t_c1[0]), .b(t_c1[1]), .c(t_c1[2]), .d(t_c1[3]), .s0(y_c1[0]), .s1(y_c1[1])
  );

  // Next-state: row states advance on an input beat, emit states on an output beat.
  always_comb begin
    state_nxt = state;
    case (state)
      S_ROW0:  if (accept) state_nxt = S_ROW1;
      S_ROW1:  if (accept) state_nxt = S_ROW2;
      S_ROW2:  if (accept) state_nxt = S_ROW3;
      S_ROW3:  if (accept) state_nxt = S_EMIT0;
      S_EMIT0: if (out_ready) state_nxt = S_EMIT1;
      S_EMIT1: if (out_ready) state_nxt = S_ROW0;
      default: state_nxt = S_ROW0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_ROW0;
    else        state <= state_nxt;
  end

  // Row-transform buffer and per-tile mode; ROW0..ROW3 encode the row index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < TILE_IN; k++) begin
        t_c0[k] <= '0;
        t_c1[k] <= '0;
      end
      tile_mode <= 1'b0;
    end else if (accept) begin
      t_c0[state[1:0]] <= row_s0;
      t_c1[state[1:0]] <= row_s1;
      if (state == S_ROW0) tile_mode <= mode;
    end
  end

  // Select the current Y row, then round, shift and saturate each element.
  always_comb begin
    sel[0] = out_row ? y_c0[1] : y_c0[0];
    sel[1] = out_row ? y_c1[1] : y_c1[0];
    for (int e = 0; e < TILE_OUT; e++) begin
      ext[e] = sel[e];
      ext[e] = ext[e] + RND;
      shf[e] = ext[e] >>> SHIFT;
      hit[e] = 1'b0;
      if (shf[e] > SAT_HI) begin
        clip[e] = {1'b0, {(OW-1){1'b1}}};
        hit[e]  = 1'b1;
      end else if (shf[e] < SAT_LO) begin
        clip[e] = {1'b1, {(OW-1){1'b0}}};
        hit[e]  = 1'b1;
      end else begin
        clip[e] = shf[e][OW-1:0];
      end
    end
  end

  assign out_valid = emit;
  assign out_row   = (state == S_EMIT1);
  assign out_y0    = (emit && tile_mode == MODE_RFCONV) ? clip[0] : '0;
  assign out_y1    = (emit && tile_mode == MODE_RFCONV) ? clip[1] : '0;
  assign out_sat   = emit && (tile_mode == MODE_RFCONV) && (|hit);

endmodule
